// File: rtl/wb_arb_pkg.sv
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types and constants for the round-robin Wishbone
//               arbiter: FSM state encoding, default timeout and the data
//               word returned on a forced termination.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int          TIMEOUT_DEFAULT = 255;
  localparam logic [31:0] ARB_ERR_DATA    = 32'hDEADBEEF;
  // Width of the stall counter used when the timeout feature is built in.
  localparam int          TO_CNT_W        = 16;

endpackage

`default_nettype wire

// File: rtl/wb_rr_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns a one-hot grant for
//               the first asserted request at or after ptr_i, wrapping from
//               N-1 back to 0. Zero when no request is asserted.
// Ports       : req_i [N]   request vector
//               ptr_i [PW]  highest-priority index
//               gnt_o [N]   one-hot grant
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  localparam int SW = PW + 1;

  logic          found;
  logic [SW-1:0] sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      // Modular walk starting at the pointer; one extra bit avoids overflow
      // before the wrap subtraction.
      sum = {1'b0, ptr_i} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Round-robin Wishbone arbiter sharing one slave port among
//               N_MASTERS masters. Grant is registered and held while the
//               granted master keeps cyc high; one idle cycle separates
//               consecutive grants. Optional stall timeout is compiled in
//               with macro WB_ARB_TIMEOUT_EN.
// Ports       : clk, reset (sync, active high)
//               m_cyc_i/m_stb_i/m_we_i [N], m_adr_i/m_dat_i [32N], m_sel_i [4N]
//               m_dat_o [32] (broadcast), m_ack_o [N]
//               s_cyc_o/s_stb_o/s_we_o, s_adr_o/s_dat_o [32], s_sel_o [4]
//               s_dat_i [32], s_ack_i
//               grant_o [N] one-hot grant, timeout_o sticky forced-end flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [32*N_MASTERS-1:0] m_adr_i,
  input  logic [32*N_MASTERS-1:0] m_dat_i,
  input  logic [4*N_MASTERS-1:0]  m_sel_i,
  output logic [31:0]             m_dat_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  output logic [3:0]              s_sel_o,
  input  logic [31:0]             s_dat_i,
  input  logic                    s_ack_i,
  output logic [N_MASTERS-1:0]    grant_o,
  output logic                    timeout_o
);

  localparam int PW = $clog2(N_MASTERS);

  arb_state_e             state_q;
  logic [N_MASTERS-1:0]   grant_q;
  logic [PW-1:0]          ptr_q;
  logic [N_MASTERS-1:0]   w_pick;
  logic [PW-1:0]          w_gidx;
  logic                   w_gcyc;
  logic                   w_expire;

  logic [31:0] w_adr [N_MASTERS];
  logic [31:0] w_dat [N_MASTERS];
  logic [3:0]  w_sel [N_MASTERS];

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
    assign w_adr[k] = m_adr_i[32*k +: 32];
    assign w_dat[k] = m_dat_i[32*k +: 32];
    assign w_sel[k] = m_sel_i[4*k +: 4];
  end

  rr_pick #(.N(N_MASTERS), .PW(PW)) u_pick (
    .req_i (m_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (w_pick)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) w_gidx = PW'(i);
    end
  end

  // Slave-side mux. Everything is 0 in IDLE; stb is only forwarded while the
  // granted master also holds cyc.
  always_comb begin
    w_gcyc  = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (state_q == BUSY) begin
      w_gcyc  = m_cyc_i[w_gidx];
      s_stb_o = m_cyc_i[w_gidx] & m_stb_i[w_gidx];
      s_we_o  = m_we_i[w_gidx];
      s_adr_o = w_adr[w_gidx];
      s_dat_o = w_dat[w_gidx];
      s_sel_o = w_sel[w_gidx];
    end
  end

  assign s_cyc_o = w_gcyc;
  assign grant_o = grant_q;

  // An ack arriving after the master dropped cyc belongs to an aborted
  // transfer and is swallowed.
  assign m_ack_o = grant_q & {N_MASTERS{w_gcyc & (s_ack_i | w_expire)}};
  assign m_dat_o = w_expire ? ARB_ERR_DATA : s_dat_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            grant_q <= w_pick;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!w_gcyc) begin
            grant_q <= '0;
            ptr_q   <= (w_gidx == PW'(N_MASTERS - 1)) ? '0 : w_gidx + 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] to_cnt_q;
  logic [TO_CNT_W-1:0] to_cnt_d;
  logic [TO_CNT_W-1:0] w_cnt_cur;
  logic                stb_q;
  logic                timeout_q;
  logic                w_stall;

  assign w_stall   = s_stb_o & ~s_ack_i;
  // A fresh strobe starts from zero regardless of any leftover count.
  assign w_cnt_cur = (s_stb_o & ~stb_q) ? '0 : to_cnt_q;
  // Ack in the expiry cycle wins because w_stall excludes s_ack_i.
  assign w_expire  = w_stall & (w_cnt_cur == TO_CNT_W'(TIMEOUT - 1));

  always_comb begin
    to_cnt_d = w_cnt_cur;
    if (state_q != BUSY || s_ack_i || w_expire) to_cnt_d = '0;
    else if (w_stall)                           to_cnt_d = w_cnt_cur + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= '0;
      stb_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      stb_q     <= s_stb_o;
      timeout_q <= timeout_q | w_expire;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign w_expire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
// ============================================================================
// Module      : tb_wb_rr_arbiter
// Description : Self-checking bench for wb_rr_arbiter (N_MASTERS=2). Directed
//               scenarios plus a randomized run against a reference model of
//               the grant rotation. Honors WB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_rr_arbiter;

  localparam int N = 2;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  m_cyc, m_stb, m_we;
  logic [32*N-1:0] m_adr, m_dat;
  logic [4*N-1:0]  m_sel;
  logic [31:0]   m_dat_o;
  logic [N-1:0]  m_ack_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_dat;
  logic          s_ack;
  logic [N-1:0]  grant_o;
  logic          timeout_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: granted master index (-1 when none) and rotation pointer.
  int mg   = -1;
  int mptr = 0;

  wb_rr_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_sel_i   (m_sel),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_dat_i   (s_dat),
    .s_ack_i   (s_ack),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock edge; the model advances using the inputs held across the edge.
  task automatic clk_step();
    int k;
    @(posedge clk);
    if (reset) begin
      mg   = -1;
      mptr = 0;
    end else if (mg < 0) begin
      for (int i = 0; i < N; i++) begin
        k = (mptr + i) % N;
        if (mg < 0 && m_cyc[k]) mg = k;
      end
    end else if (!m_cyc[mg]) begin
      mptr = (mg + 1) % N;
      mg   = -1;
    end
    #1;
  endtask

  task automatic idle_all();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = 1'b0; s_dat = '0;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    clk_step();
    clk_step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_all();
    m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
    reset = 1'b1;
    clk_step();
    clk_step();
    n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
    n_vec++; if (s_cyc_o !== 1'b0) begin n_err++; $display("FAIL reset_scyc: got %b expected 0", s_cyc_o); end
    n_vec++; if (s_stb_o !== 1'b0) begin n_err++; $display("FAIL reset_sstb: got %b expected 0", s_stb_o); end
    n_vec++; if (m_ack_o !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b expected 00", m_ack_o); end
    n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
    idle_all();
    reset = 1'b0;
    clk_step();
  endtask

  task automatic test_single();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
    m_adr[31:0] = 32'h0000_0010; m_sel[3:0] = 4'hF;
    #1;
    n_vec++; if (s_cyc_o !== 1'b0) begin n_err++; $display("FAIL single_latency: s_cyc got %b expected 0 before edge", s_cyc_o); end
    clk_step();
    n_vec++; if (s_cyc_o !== 1'b1) begin n_err++; $display("FAIL single_scyc: got %b expected 1", s_cyc_o); end
    n_vec++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b expected 01", grant_o); end
    n_vec++; if (s_adr_o !== 32'h10) begin n_err++; $display("FAIL single_adr: got %h expected 00000010", s_adr_o); end
    clk_step();
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    #1;
    n_vec++; if (m_ack_o !== 2'b01) begin n_err++; $display("FAIL single_ack: got %b expected 01", m_ack_o); end
    n_vec++; if (m_dat_o !== 32'h1234_5678) begin n_err++; $display("FAIL single_data: got %h expected 12345678", m_dat_o); end
    clk_step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    clk_step();
    n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL single_release: got %b expected 00", grant_o); end
    n_vec++; if (s_adr_o !== 32'h0) begin n_err++; $display("FAIL single_idle_adr: got %h expected 0", s_adr_o); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    m_adr = {32'h0000_0200, 32'h0000_0100};
    clk_step();
    n_vec++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL simul_first: got %b expected 01", grant_o); end
    n_vec++; if (s_adr_o !== 32'h100) begin n_err++; $display("FAIL simul_adr0: got %h expected 00000100", s_adr_o); end
    s_ack = 1'b1; #1;
    n_vec++; if (m_ack_o !== 2'b01) begin n_err++; $display("FAIL simul_ack0: got %b expected 01", m_ack_o); end
    clk_step();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    clk_step();
    n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL simul_dead: got %b expected 00", grant_o); end
    n_vec++; if (s_stb_o !== 1'b0) begin n_err++; $display("FAIL simul_dead_stb: got %b expected 0", s_stb_o); end
    clk_step();
    n_vec++; if (grant_o !== 2'b10) begin n_err++; $display("FAIL simul_second: got %b expected 10", grant_o); end
    n_vec++; if (s_adr_o !== 32'h200) begin n_err++; $display("FAIL simul_adr1: got %h expected 00000200", s_adr_o); end
    s_ack = 1'b1; #1;
    n_vec++; if (m_ack_o !== 2'b10) begin n_err++; $display("FAIL simul_ack1: got %b expected 10", m_ack_o); end
    clk_step();
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    clk_step();
    m_cyc = 2'b11; m_stb = 2'b11;
    clk_step();
    n_vec++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL simul_ptr_wrap: got %b expected 01", grant_o); end
    idle_all();
    clk_step();
  endtask

  task automatic test_alternate();
    logic [N-1:0] exp_g;
    logic [N-1:0] prev_g;
    int           waited;
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    prev_g = 2'b00;
    for (int r = 0; r < 4; r++) begin
      waited = 0;
      while (grant_o == 2'b00 && waited < 4) begin
        clk_step();
        waited++;
      end
      exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
      n_vec++; if (grant_o !== exp_g) begin n_err++; $display("FAIL alt_grant[%0d]: got %b expected %b", r, grant_o, exp_g); end
      n_vec++; if (grant_o === prev_g) begin n_err++; $display("FAIL alt_repeat[%0d]: got %b expected not %b", r, grant_o, prev_g); end
      m_cyc = m_cyc & ~exp_g;
      clk_step();
      m_cyc = 2'b11;
      prev_g = exp_g;
    end
    idle_all();
    clk_step();
    clk_step();
  endtask

  task automatic test_burst();
    logic [31:0] exp_adr;
    do_reset();
    exp_adr = 32'h0000_0300;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[63:32] = exp_adr; m_dat[63:32] = 32'hAAAA_5555;
    clk_step();
    n_vec++; if (grant_o !== 2'b10) begin n_err++; $display("FAIL burst_grant: got %b expected 10", grant_o); end
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h0000_0400;
    s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_dat = 32'(b);
      #1;
      n_vec++; if (m_ack_o !== 2'b10) begin n_err++; $display("FAIL burst_ack[%0d]: got %b expected 10", b, m_ack_o); end
      n_vec++; if (s_adr_o !== exp_adr) begin n_err++; $display("FAIL burst_adr[%0d]: got %h expected %h", b, s_adr_o, exp_adr); end
      n_vec++; if (s_we_o !== 1'b1 || s_dat_o !== 32'hAAAA_5555) begin n_err++; $display("FAIL burst_wdata[%0d]: got we=%b dat=%h expected we=1 dat=aaaa5555", b, s_we_o, s_dat_o); end
      clk_step();
      exp_adr = exp_adr + 32'd4;
      m_adr[63:32] = exp_adr;
    end
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    clk_step();
    n_vec++; if (grant_o !== 2'b00 || s_stb_o !== 1'b0) begin n_err++; $display("FAIL burst_gap: got grant=%b stb=%b expected 00/0", grant_o, s_stb_o); end
    clk_step();
    n_vec++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL burst_next: got %b expected 01", grant_o); end
    n_vec++; if (s_adr_o !== 32'h400) begin n_err++; $display("FAIL burst_next_adr: got %h expected 00000400", s_adr_o); end
    idle_all();
    clk_step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    clk_step();
    s_ack = 1'b1;
    clk_step();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    clk_step();
    m_cyc = 2'b11; m_stb = 2'b11;
    clk_step();
    n_vec++; if (grant_o !== 2'b10) begin n_err++; $display("FAIL rmid_pre: got %b expected 10", grant_o); end
    s_ack = 1'b1;
    reset = 1'b1;
    clk_step();
    n_vec++; if (s_cyc_o !== 1'b0) begin n_err++; $display("FAIL rmid_scyc: got %b expected 0", s_cyc_o); end
    n_vec++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL rmid_grant: got %b expected 00", grant_o); end
    n_vec++; if (m_ack_o !== 2'b00) begin n_err++; $display("FAIL rmid_ack: got %b expected 00", m_ack_o); end
    reset = 1'b0; s_ack = 1'b0;
    clk_step();
    n_vec++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL rmid_after: got %b expected 01", grant_o); end
    idle_all();
    clk_step();
    clk_step();
  endtask

  task automatic test_timeout();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    clk_step();
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k < TO; k++) begin
      n_vec++; if (m_ack_o !== 2'b00) begin n_err++; $display("FAIL to_early[%0d]: got %b expected 00", k, m_ack_o); end
      clk_step();
    end
    n_vec++; if (m_ack_o !== 2'b01) begin n_err++; $display("FAIL to_ack: got %b expected 01", m_ack_o); end
    n_vec++; if (m_dat_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL to_data: got %h expected deadbeef", m_dat_o); end
    clk_step();
    m_cyc = '0; m_stb = '0;
    #1;
    n_vec++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b expected 1", timeout_o); end
    n_vec++; if (m_ack_o !== 2'b00) begin n_err++; $display("FAIL to_single_ack: got %b expected 00", m_ack_o); end
    for (int k = 0; k < 3; k++) clk_step();
    n_vec++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b expected 1", timeout_o); end
`else
    for (int k = 0; k < 20; k++) begin
      n_vec++; if (m_ack_o !== 2'b00) begin n_err++; $display("FAIL noto_ack[%0d]: got %b expected 00", k, m_ack_o); end
      clk_step();
    end
    n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL noto_flag: got %b expected 0", timeout_o); end
`endif
    idle_all();
    clk_step();
  endtask

  task automatic test_random();
    logic [N-1:0] egnt, eack;
    logic         ecyc, estb;
    int           stall;
    do_reset();
    stall = 0;
    for (int c = 0; c < 600; c++) begin
      // Expected outputs for the present cycle.
      egnt = '0; ecyc = 1'b0; estb = 1'b0; eack = '0;
      if (mg >= 0) begin
        egnt[mg] = 1'b1;
        ecyc = m_cyc[mg];
        estb = m_cyc[mg] & m_stb[mg];
        if (ecyc && s_ack) eack[mg] = 1'b1;
      end
      n_vec++; if (grant_o !== egnt) begin n_err++; $display("FAIL rnd_grant@%0d: got %b expected %b", c, grant_o, egnt); end
      n_vec++; if (s_cyc_o !== ecyc || s_stb_o !== estb) begin n_err++; $display("FAIL rnd_cycstb@%0d: got %b%b expected %b%b", c, s_cyc_o, s_stb_o, ecyc, estb); end
      n_vec++; if (m_ack_o !== eack) begin n_err++; $display("FAIL rnd_ack@%0d: got %b expected %b", c, m_ack_o, eack); end
      if (mg >= 0) begin
        n_vec++;
        if (s_adr_o !== m_adr[32*mg +: 32] || s_dat_o !== m_dat[32*mg +: 32] ||
            s_sel_o !== m_sel[4*mg +: 4] || s_we_o !== m_we[mg]) begin
          n_err++;
          $display("FAIL rnd_fwd@%0d: got adr=%h dat=%h sel=%h we=%b expected master %0d", c, s_adr_o, s_dat_o, s_sel_o, s_we_o, mg);
        end
      end else begin
        n_vec++; if (s_adr_o !== 32'h0 || s_we_o !== 1'b0) begin n_err++; $display("FAIL rnd_idle@%0d: got adr=%h we=%b expected 0", c, s_adr_o, s_we_o); end
      end
      if (eack != '0) begin
        n_vec++; if (m_dat_o !== s_dat) begin n_err++; $display("FAIL rnd_rdata@%0d: got %h expected %h", c, m_dat_o, s_dat); end
      end
      if (estb && !s_ack) stall++;
      else stall = 0;

      clk_step();

      for (int k = 0; k < N; k++) begin
        if (!m_cyc[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            m_cyc[k] = 1'b1; m_stb[k] = 1'b1; m_we[k] = 1'($urandom);
            m_adr[32*k +: 32] = $urandom; m_dat[32*k +: 32] = $urandom;
            m_sel[4*k +: 4] = 4'($urandom);
          end
        end else if (k == mg) begin
          if (eack[k]) begin
            if ($urandom_range(0, 1) == 0) begin
              m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
            end else begin
              m_adr[32*k +: 32] = $urandom; m_dat[32*k +: 32] = $urandom;
            end
          end else if ($urandom_range(0, 15) == 0) begin
            m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
          end else if ($urandom_range(0, 7) == 0) begin
            m_stb[k] = ~m_stb[k];
          end
        end
      end
      estb = (mg >= 0) && m_cyc[mg] && m_stb[mg];
      if (estb) s_ack = (stall >= 3) || ($urandom_range(0, 1) == 0);
      else      s_ack = ($urandom_range(0, 7) == 0);
      s_dat = $urandom;
      #1;
    end
    idle_all();
    clk_step();
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_single();
    test_simultaneous();
    test_alternate();
    test_burst();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
